// File: rtl/ps_gp_reg_bank.sv
// PS general-purpose register bank: two-stage write decode into NUM_GRP x NUM_REG
// control registers with byte enables, pulse and shadow/commit modes. Readback is optional via GP_READBACK_EN.
module ps_gp_reg_bank #(
  parameter int ADDR_L_W = 10,
  parameter int NUM_GRP  = 5,
  parameter int NUM_REG  = 36,
  parameter logic [NUM_GRP*NUM_REG-1:0] PULSE_MASK  = '0,
  parameter logic [NUM_GRP*NUM_REG-1:0] SHADOW_MASK = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   addr,
  input  logic [31:0]                   data,
  input  logic [3:0]                    be,
  input  logic                          wren,
  input  logic                          upd,
  input  logic                          rd_en,
  input  logic [31:0]                   rd_addr,
  output logic                          wr_ack,
  output logic                          wr_err,
  output logic                          pending,
  output logic [31:0]                   rd_data,
  output logic                          rd_valid,
  output logic [NUM_GRP*NUM_REG*32-1:0] reg_q
);

  localparam int NR     = NUM_GRP * NUM_REG;
  localparam int FLAT_W = (NR > 1) ? $clog2(NR) : 1;
  localparam int GRP_W  = 32 - ADDR_L_W;
  localparam logic [GRP_W-1:0]  GRP_LIM = GRP_W'(NUM_GRP);
  localparam logic [ADDR_L_W:0] IDX_LIM = (ADDR_L_W + 1)'(NUM_REG);

  function automatic logic dec_hit(input logic [31:0] a);
    return (a[31:ADDR_L_W] < GRP_LIM) && ({1'b0, a[ADDR_L_W-1:0]} < IDX_LIM);
  endfunction

  // Only meaningful when dec_hit is true; then the result always fits FLAT_W bits.
  function automatic logic [FLAT_W-1:0] dec_flat(input logic [31:0] a);
    return FLAT_W'(a[31:ADDR_L_W]) * FLAT_W'(NUM_REG) + FLAT_W'(a[ADDR_L_W-1:0]);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0]  b);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = b[k] ? d[8*k +: 8] : old[8*k +: 8];
    return r;
  endfunction

  logic              s1_vld;
  logic              s1_hit;
  logic [FLAT_W-1:0] s1_flat;
  logic [31:0]       s1_data;
  logic [3:0]        s1_be;
  logic [NR-1:0]     shd_wr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld  <= 1'b0;
      s1_hit  <= 1'b0;
      s1_flat <= '0;
      s1_data <= '0;
      s1_be   <= '0;
    end else begin
      s1_vld  <= wren;
      s1_hit  <= wren && dec_hit(addr);
      s1_flat <= dec_flat(addr);
      s1_data <= data;
      s1_be   <= be;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      wr_ack <= s1_vld && s1_hit;
      wr_err <= s1_vld && !s1_hit;
    end
  end

`ifdef GP_READBACK_EN
  logic [NR*32-1:0] rd_vals;
`endif

  for (genvar i = 0; i < NR; i++) begin : g_reg
    localparam bit IS_PULSE  = PULSE_MASK[i];
    localparam bit IS_SHADOW = SHADOW_MASK[i] && !PULSE_MASK[i];
    logic        hit;
    logic [31:0] act;

    assign hit = s1_hit && (s1_flat == FLAT_W'(i));

    if (IS_PULSE) begin : g_pulse
      // Unwritten bytes are zero during the pulse cycle.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) act <= '0;
        else      act <= hit ? merge(32'h0, s1_data, s1_be) : 32'h0;
      end
      assign shd_wr[i] = 1'b0;
`ifdef GP_READBACK_EN
      assign rd_vals[i*32 +: 32] = 32'h0;
`endif
    end else if (IS_SHADOW) begin : g_shadow
      logic [31:0] shd;
      // A commit coinciding with a write moves the old shadow value to active.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          shd <= '0;
          act <= '0;
        end else begin
          if (hit) shd <= merge(shd, s1_data, s1_be);
          if (upd) act <= shd;
        end
      end
      assign shd_wr[i] = hit;
`ifdef GP_READBACK_EN
      assign rd_vals[i*32 +: 32] = hit ? merge(shd, s1_data, s1_be) : shd;
`endif
    end else begin : g_plain
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)     act <= '0;
        else if (hit) act <= merge(act, s1_data, s1_be);
      end
      assign shd_wr[i] = 1'b0;
`ifdef GP_READBACK_EN
      assign rd_vals[i*32 +: 32] = hit ? merge(act, s1_data, s1_be) : act;
`endif
    end

    assign reg_q[i*32 +: 32] = act;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         pending <= 1'b0;
    else if (|shd_wr) pending <= 1'b1;
    else if (upd)     pending <= 1'b0;
  end

`ifdef GP_READBACK_EN
  logic              rd_hit;
  logic [FLAT_W-1:0] rd_flat;
  logic [31:0]       rd_sel;

  assign rd_hit  = dec_hit(rd_addr);
  assign rd_flat = dec_flat(rd_addr);

  // rd_vals already includes a write landing on the same edge as the read.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NR; i++)
      if (rd_flat == FLAT_W'(i)) rd_sel = rd_vals[i*32 +: 32];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_hit ? rd_sel : 32'h0;
    end
  end
`else
  logic unused_rd;
  assign unused_rd = ^{rd_en, rd_addr};
  assign rd_valid  = 1'b0;
  assign rd_data   = '0;
`endif

endmodule

// File: tb/tb_ps_gp_reg_bank.sv
// Directed bench for ps_gp_reg_bank: pulse at (1,1), shadow at (2,5), pulse+shadow at (3,0).
module tb_ps_gp_reg_bank;
  localparam int NG = 5;
  localparam int NRG = 36;
  localparam int N = NG * NRG;
  localparam logic [N-1:0] PM = (N'(1) << 37) | (N'(1) << 108);
  localparam logic [N-1:0] SM = (N'(1) << 77) | (N'(1) << 108);

  logic clk = 1'b0;
  logic rst;
  logic [31:0] addr, data, rd_addr;
  logic [3:0] be;
  logic wren, upd, rd_en;
  logic wr_ack, wr_err, pending, rd_valid;
  logic [31:0] rd_data;
  logic [N*32-1:0] reg_q;

  logic [31:0] exp_q [N];
  int total = 0;
  int bad = 0;

  ps_gp_reg_bank #(
    .ADDR_L_W(10), .NUM_GRP(NG), .NUM_REG(NRG), .PULSE_MASK(PM), .SHADOW_MASK(SM)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .be(be), .wren(wren),
    .upd(upd), .rd_en(rd_en), .rd_addr(rd_addr), .wr_ack(wr_ack), .wr_err(wr_err),
    .pending(pending), .rd_data(rd_data), .rd_valid(rd_valid), .reg_q(reg_q)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1);
  end

  function automatic logic [31:0] mk(input int g, input int i);
    return (32'(g) << 10) | 32'(i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int g, input int i, input logic [31:0] d, input logic [3:0] b);
    addr = mk(g, i);
    data = d;
    be   = b;
    wren = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_regs(input string tag);
    logic [N*32-1:0] e;
    int k;
    k = 0;
    for (int i = 0; i < N; i++) e[i*32 +: 32] = exp_q[i];
    for (int i = N - 1; i >= 0; i--) if (reg_q[i*32 +: 32] !== exp_q[i]) k = i;
    total++;
    assert (reg_q === e) else begin
      bad++;
      $error("FAIL %s: reg[%0d] observed=%h expected=%h", tag, k, reg_q[k*32 +: 32], exp_q[k]);
    end
  endtask

  task automatic rd(input int g, input int i);
    rd_addr = mk(g, i);
    rd_en   = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) exp_q[i] = 32'h0;
    rst = 1'b0; addr = '0; data = '0; be = '0; wren = 1'b0; upd = 1'b0;
    rd_en = 1'b0; rd_addr = '0;
    tick(); tick();
    chk_regs("reset_regs");
    chk("reset_ack", 32'(wr_ack), 0);
    chk("reset_pending", 32'(pending), 0);
    chk("reset_rd_valid", 32'(rd_valid), 0);
    #3 rst = 1'b1;
    tick();

    // basic write (1,2) = 0xAB
    wr(1, 2, 32'h0000_00AB, 4'hF);
    tick(); wren = 1'b0;
    chk_regs("wr_edge_n");
    chk("wr_ack_early", 32'(wr_ack), 0);
    tick(); exp_q[38] = 32'hAB;
    chk_regs("wr_edge_n1");
    chk("wr_ack_hi", 32'(wr_ack), 1);
    chk("wr_err_lo", 32'(wr_err), 0);
    tick();
    chk("wr_ack_drop", 32'(wr_ack), 0);

    // misses: bad group, bad index
    wr(7, 2, 32'hFFFF_FFFF, 4'hF);
    tick(); wren = 1'b0;
    tick();
    chk("miss_grp_err", 32'(wr_err), 1);
    chk("miss_grp_ack", 32'(wr_ack), 0);
    chk_regs("miss_grp_regs");
    tick();
    chk("miss_grp_err_drop", 32'(wr_err), 0);
    wr(0, 40, 32'hFFFF_FFFF, 4'hF);
    tick(); wren = 1'b0;
    tick();
    chk("miss_idx_err", 32'(wr_err), 1);
    chk_regs("miss_idx_regs");
    tick();

    // pulse register (1,1)
    wr(1, 1, 32'h1, 4'hF);
    tick(); wren = 1'b0;
    tick(); exp_q[37] = 32'h1;
    chk_regs("pulse_hi");
    tick(); exp_q[37] = 32'h0;
    chk_regs("pulse_lo");
    wr(1, 1, 32'h1, 4'hF);
    tick();
    tick(); wren = 1'b0; exp_q[37] = 32'h1;
    chk_regs("pulse2_c1");
    tick();
    chk_regs("pulse2_c2");
    chk("pulse2_ack2", 32'(wr_ack), 1);
    tick(); exp_q[37] = 32'h0;
    chk_regs("pulse2_lo");
    chk("pulse2_ack_lo", 32'(wr_ack), 0);
    wr(1, 1, 32'hAABB_CCDD, 4'h2);
    tick(); wren = 1'b0;
    tick(); exp_q[37] = 32'h0000_CC00;
    chk_regs("pulse_be");
    tick(); exp_q[37] = 32'h0;
    chk_regs("pulse_be_lo");

    // shadow register (2,5)
    wr(2, 5, 32'h1234, 4'hF);
    tick(); wren = 1'b0;
    tick();
    chk_regs("shadow_hold");
    chk("shadow_pending", 32'(pending), 1);
    rd(2, 5);
    tick(); rd_en = 1'b0;
`ifdef GP_READBACK_EN
    chk("rd_shadow", rd_data, 32'h1234);
    chk("rd_shadow_valid", 32'(rd_valid), 1);
`else
    chk("rd_off_data", rd_data, 0);
    chk("rd_off_valid", 32'(rd_valid), 0);
`endif
    upd = 1'b1;
    tick(); upd = 1'b0; exp_q[77] = 32'h1234;
    chk_regs("commit");
    chk("commit_pending", 32'(pending), 0);
    wr(2, 5, 32'h5678, 4'hF);
    tick(); wren = 1'b0; upd = 1'b1;
    tick(); upd = 1'b0;
    chk_regs("commit_coincident");
    chk("coincident_pending", 32'(pending), 1);
    upd = 1'b1;
    tick(); upd = 1'b0; exp_q[77] = 32'h5678;
    chk_regs("commit2");
    chk("commit2_pending", 32'(pending), 0);

    // byte enables and back-to-back last-wins
    wr(0, 3, 32'h1122_3344, 4'hF);
    tick(); wr(0, 3, 32'hAABB_CCDD, 4'h2);
    tick(); wren = 1'b0; exp_q[3] = 32'h1122_3344;
    chk_regs("be_first");
    tick(); exp_q[3] = 32'h1122_CC44;
    chk_regs("be_merge");
    wr(0, 4, 32'h1, 4'hF);
    tick(); wr(0, 4, 32'h2, 4'hF);
    tick(); wren = 1'b0; exp_q[4] = 32'h1;
    chk_regs("b2b_first");
    tick(); exp_q[4] = 32'h2;
    chk_regs("b2b_last");

    // pulse beats shadow at (3,0)
    wr(3, 0, 32'h55, 4'hF);
    tick(); wren = 1'b0;
    tick(); exp_q[108] = 32'h55;
    chk_regs("ps_pulse_hi");
    chk("ps_pending", 32'(pending), 0);
    tick(); exp_q[108] = 32'h0;
    chk_regs("ps_pulse_lo");

    // readback of plain, pulse, miss, and same-edge write
    rd(1, 2);
    tick(); rd_en = 1'b0;
`ifdef GP_READBACK_EN
    chk("rd_plain", rd_data, 32'hAB);
    chk("rd_plain_valid", 32'(rd_valid), 1);
`endif
    tick();
    chk("rd_valid_drop", 32'(rd_valid), 0);
    rd(1, 1);
    tick(); rd_en = 1'b0;
    chk("rd_pulse", rd_data, 0);
    rd(9, 0);
    tick(); rd_en = 1'b0;
    chk("rd_miss", rd_data, 0);
    wr(0, 6, 32'hCAFE, 4'hF);
    tick(); wren = 1'b0; rd(0, 6);
    tick(); rd_en = 1'b0; exp_q[6] = 32'hCAFE;
`ifdef GP_READBACK_EN
    chk("rd_forward", rd_data, 32'hCAFE);
`else
    chk("rd_off_forward", rd_data, 0);
`endif
    chk_regs("forward_regs");

    // reset mid-write with pending set
    wr(2, 5, 32'h77, 4'hF);
    tick(); wren = 1'b0;
    tick();
    chk("pre_rst_pending", 32'(pending), 1);
    wr(0, 5, 32'h99, 4'hF);
    tick(); wren = 1'b0;
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < N; i++) exp_q[i] = 32'h0;
    chk_regs("rst_regs");
    chk("rst_pending", 32'(pending), 0);
    chk("rst_ack", 32'(wr_ack), 0);
    chk("rst_err", 32'(wr_err), 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    tick(); tick();
    #3 rst = 1'b1;
    tick();
    chk("post_rst_ack1", 32'(wr_ack), 0);
    tick();
    chk("post_rst_ack2", 32'(wr_ack), 0);
    chk_regs("post_rst_regs");

    // first write right after release
    #3 rst = 1'b0;
    tick();
    #3 rst = 1'b1;
    wr(1, 2, 32'hCD, 4'hF);
    tick(); wren = 1'b0;
    tick(); exp_q[38] = 32'hCD;
    chk_regs("first_after_rst");
    chk("first_after_rst_ack", 32'(wr_ack), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
